// File: rtl/frame_prefetch.sv
// frame_prefetch: fetches one frame of pixel words over a pipelined read master and pushes them into the pixel FIFO; optional sticky protocol error output when FRAME_PREFETCH_ERR_EN is defined
module frame_prefetch #(
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 16,
  parameter int FRAME_WORDS     = 307200,
  parameter int FREE_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic                  mem_waitrequest,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_readdatavalid,
  output logic                  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_wrdone,
  input  logic [FREE_WIDTH-1:0] fifo_num_free
`ifdef FRAME_PREFETCH_ERR_EN
  ,
  output logic                  error
`endif
);
  localparam int RW = $clog2(FRAME_WORDS + 1);
  localparam int MW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = FREE_WIDTH > MW ? FREE_WIDTH : MW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q;
  logic busy_q, done_q, mem_read_q, wren_q, acc, present, take;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] reserved_q, reserved_d;
  // request acceptance, reservation gating and next-state counters
  always_comb begin
    acc = mem_read_q && !mem_waitrequest;
    addr_d = acc ? addr_q + ADDR_WIDTH'(1) : addr_q;
    remaining_d = acc ? remaining_q - RW'(1) : remaining_q;
    present = state_q == RUN && (!mem_read_q || acc) && remaining_d != '0 &&
              reserved_q < CW'(MAX_OUTSTANDING) && CW'(fifo_num_free) > reserved_q;
    reserved_d = reserved_q + CW'(present) - CW'(fifo_wrdone && reserved_q != '0);
    take = mem_readdatavalid && state_q != IDLE;
  end
  // frame FSM with registered read-master and FIFO-write outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mem_read_q <= 1'b0;
      wren_q <= 1'b0;
      addr_q <= '0;
      wrdata_q <= '0;
      remaining_q <= '0;
      reserved_q <= '0;
    end else begin
      done_q <= 1'b0;
      wren_q <= take;
      if (take) wrdata_q <= mem_readdata;
      case (state_q)
        IDLE: if (start) begin
          addr_q <= base_addr;
          remaining_q <= RW'(FRAME_WORDS);
          reserved_q <= '0;
          busy_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          addr_q <= addr_d;
          remaining_q <= remaining_d;
          reserved_q <= reserved_d;
          mem_read_q <= present || (mem_read_q && !acc);
          if (acc && remaining_d == '0) state_q <= DRAIN;
        end
        DRAIN: begin
          reserved_q <= reserved_d;
          if (reserved_d == '0) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign mem_read = mem_read_q;
  assign mem_address = addr_q;
  assign fifo_wren = wren_q;
  assign fifo_wrdata = wrdata_q;
`ifdef FRAME_PREFETCH_ERR_EN
  logic err_q, chk_q;
  // sticky error: missing write acknowledge or data returned with nothing reserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      chk_q <= 1'b0;
    end else begin
      chk_q <= wren_q;
      if (state_q == IDLE && start) err_q <= 1'b0;
      else if ((chk_q && !fifo_wrdone) || (mem_readdatavalid && reserved_q == '0)) err_q <= 1'b1;
    end
  end
  assign error = err_q;
`endif
endmodule

// File: doc/frame_prefetch.md
Name: frame_prefetch

Overview:
- Write-side producer for the pixel FIFO: fetches one frame of pixel words from frame-buffer memory over a pipelined read master and pushes them into the FIFO write port (wren/wrdata/wrdone).
- Uses FIFO num_free plus its own reservation count so the FIFO never sees a write while full.
- Sits between the SDRAM/avalon read path and the FIFO that feeds the VGA timing/pixel output stage.

Parameters:
- ADDR_WIDTH, 24, memory word-address width
- DATA_WIDTH, 16, pixel word width; equals FIFO DATA_WIDTH
- FRAME_WORDS, 307200, words fetched per frame (640x480)
- FREE_WIDTH, 8, width of fifo_num_free
- MAX_OUTSTANDING, 8, cap on reserved (issued but not yet wrdone) words

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin fetching a frame at base_addr
- base_addr  in  ADDR_WIDTH  frame start word address, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last word of the frame is written (wrdone seen)
- mem_address  out  ADDR_WIDTH  read address
- mem_read  out  1  read request
- mem_waitrequest  in  1  request stall; request accepted when mem_read && !mem_waitrequest
- mem_readdata  in  DATA_WIDTH  returned data
- mem_readdatavalid  in  1  returned data valid, in request order
- fifo_wren  out  1  FIFO write enable
- fifo_wrdata  out  DATA_WIDTH  FIFO write data
- fifo_wrdone  in  1  FIFO write acknowledge, one cycle after an accepted wren
- fifo_num_free  in  FREE_WIDTH  FIFO free entries, updated on the same edge as wrdone

Behaviour:
- Reset (async): state IDLE; busy, done, mem_read, fifo_wren = 0; mem_address, fifo_wrdata = 0; reserved, remaining = 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start: latch base_addr into the address counter, set remaining = FRAME_WORDS, reserved = 0, busy = 1, go to RUN.
  - FRAME_WORDS = 0 is illegal.
- RUN:
  - A new request is presented only when remaining > 0, reserved < MAX_OUTSTANDING, and fifo_num_free > reserved.
  - On presenting a new request, reserved increments.
  - mem_read and mem_address are held stable until accepted; mem_read never drops while waitrequest is high.
  - On acceptance: address += 1 and remaining -= 1. The next request may be presented on the following cycle, giving back-to-back throughput of one word per cycle.
  - Address wraps modulo 2^ADDR_WIDTH.
  - When the final request is accepted, go to DRAIN.
- Data path:
  - Each mem_readdatavalid registers mem_readdata into fifo_wrdata and asserts fifo_wren for exactly one cycle.
  - Latency is readdatavalid -> wren 1 cycle, wren -> wrdone 1 cycle.
  - Consecutive readdatavalid cycles produce consecutive wren cycles.
- fifo_wrdone decrements reserved.
  - Simultaneous new reservation and wrdone leaves reserved unchanged.
- DRAIN: when reserved reaches 0, pulse done for 1 cycle, drop busy, return to IDLE.
- start while busy: ignored, with no effect on the address counter or counts.
- Reset mid-frame: immediate return to IDLE. In-flight memory data arriving after reset is discarded, and no wren is generated.
- Invariant: fifo_wren is never asserted when the FIFO is full. A write without a following wrdone is a protocol violation (see optional feature).

Optional Feature:
- Macro: FRAME_PREFETCH_ERR_EN.
- Defined: adds output error (1 bit, reset 0). It sets sticky when either:
  - fifo_wren was high and fifo_wrdone is low on the next cycle, or
  - mem_readdatavalid arrives while reserved = 0.
- error clears only on reset or an accepted start.
- Undefined: no error port, no checking logic; all other behaviour identical.

Test Plan:
- Reset, then start with base_addr=0x000100, FRAME_WORDS=4, num_free=3, waitrequest=0, 2-cycle memory latency:
  - addresses 0x100..0x102 are issued, then the 4th request is held until the first wrdone.
  - wrdata sequence matches memory, done pulses once after the 4th wrdone, busy drops the same cycle.
- num_free=0 for 10 cycles after start -> mem_read stays 0; raising num_free to 2 -> exactly 2 requests issued back-to-back.
- mem_waitrequest high for 3 cycles on the first request -> mem_read and mem_address (0x100) are held stable for 4 cycles, remaining decrements only once.
- base_addr=0xFFFFFE, FRAME_WORDS=4 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Assert reset while 2 reads are in flight, then deliver 2 readdatavalid -> fifo_wren stays 0, busy=0, and a subsequent start fetches normally.
- With FRAME_PREFETCH_ERR_EN: inject readdatavalid with no request outstanding -> error=1 and stays 1 until the next start.
